async_fifo_read_drainer: RTL and testbench



---
 rtl/async_fifo_read_drainer_if.sv | 23 ++
 rtl/async_fifo_read_drainer.sv | 116 +++++++++++
 tb/tb_async_fifo_read_drainer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_read_drainer_if.sv
// FIFO read-port and output-stream signals of the read drainer.
// master = drainer side, slave = FIFO/downstream side.
interface async_fifo_read_drainer_if #(
  parameter int DW = 9
) ();
  logic [DW-1:0] data_read;
  logic          rempty;
  logic          wHalf_empty;
  logic          read_enable;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  data_read, rempty, wHalf_empty, m_ready,
    output read_enable, m_data, m_valid
  );

  modport slave (
    output data_read, rempty, wHalf_empty, m_ready,
    input  read_enable, m_data, m_valid
  );
endinterface

// File: rtl/async_fifo_read_drainer.sv
// Read-side drainer for the async FIFO: batches reads, absorbs the one-cycle
// read latency in a skid buffer and delivers words on a valid/ready stream.
//
// state   | meaning
// S_IDLE  | waiting for half-full FIFO or flush timeout
// S_DRAIN | issuing reads while FIFO non-empty and buffer has room
module async_fifo_read_drainer #(
  parameter int DW            = 9,
  parameter int BUF_DEPTH     = 4,
  parameter int FLUSH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic                         rclk,
  input  logic                         rrst,
  input  logic                         en,
  async_fifo_read_drainer_if.master    bus,
  output logic                         busy,
  output logic [CNT_W-1:0]             rd_count
);
  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W:0]    DEPTH_C   = (OCC_W + 1)'(BUF_DEPTH);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [OCC_W-1:0]  r_occ;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [DW-1:0]     r_buf [BUF_DEPTH];
  logic [CNT_W-1:0]  r_rd_count;

  logic w_have_data;
  logic w_busy;
  logic w_read_enable;
  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_have_data = en && !bus.rempty;

  always_ff @(posedge rclk) begin
    if (rrst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_have_data && (!bus.wHalf_empty || r_idle_cnt == IDLE_LAST))
                 w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_have_data) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reads count the word still in flight so the buffer can never overflow.
  always_comb begin
    w_busy        = (r_state == S_DRAIN);
    w_read_enable = w_busy && w_have_data &&
                    (({1'b0, r_occ} + (OCC_W + 1)'(r_inflight)) < DEPTH_C);
  end

  always_ff @(posedge rclk) begin
    if (rrst)
      r_idle_cnt <= '0;
    else if (r_state == S_IDLE && w_state_nxt == S_IDLE && w_have_data && bus.wHalf_empty)
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    else
      r_idle_cnt <= '0;
  end

  assign w_push = r_inflight;
  assign w_pop  = (r_occ != '0) && bus.m_ready;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_rd_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_inflight <= w_read_enable;
      if (w_push) begin
        r_buf[r_tail] <= bus.data_read;
        r_tail        <= f_next(r_tail);
      end
      if (w_pop) begin
        r_head     <= f_next(r_head);
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.read_enable = w_read_enable;
  assign bus.m_valid     = (r_occ != '0);
  assign bus.m_data      = r_buf[r_head];
  assign busy            = w_busy;
  assign rd_count        = r_rd_count;
endmodule

// File: tb/tb_async_fifo_read_drainer.sv
// Scoreboard bench: a queue-based FIFO model feeds the drainer; words read
// from the model are expected on the stream in order unless a reset drops them.
module tb_async_fifo_read_drainer;
  localparam int DW = 9, BUF_DEPTH = 4, FT = 16, CNT_W = 16, HALF = 8;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             en   = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] rd_count;

  async_fifo_read_drainer_if #(.DW(DW)) bus ();

  async_fifo_read_drainer #(
    .DW(DW), .BUF_DEPTH(BUF_DEPTH), .FLUSH_TIMEOUT(FT), .CNT_W(CNT_W)
  ) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .bus(bus), .busy(busy), .rd_count(rd_count)
  );

  always #5 rclk = ~rclk;

  int vectors = 0, miscompares = 0;
  logic [DW-1:0] fifo [$];
  logic [DW-1:0] exp_q [$];
  int   cnt_m = 0, hs_total = 0;
  logic re_pend = 1'b0, rst_e = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.rempty      = (fifo.size() == 0);
    bus.wHalf_empty = (fifo.size() <= HALF);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  // One clock: sample the read strobe mid-cycle, then answer it after the edge.
  task automatic tick();
    logic [DW-1:0] w;
    @(negedge rclk);
    #1;
    re_pend = (bus.read_enable === 1'b1);
    chk("no_underflow", {31'd0, (bus.read_enable === 1'b1 && bus.rempty === 1'b1)}, 0);
    @(posedge rclk);
    rst_e = rrst;
    #1;
    if (re_pend && fifo.size() != 0) begin
      w = fifo.pop_front();
      bus.data_read = w;
      if (!rst_e) exp_q.push_back(w);
    end else begin
      bus.data_read = DW'($urandom_range(0, 511));
    end
    if (rst_e) begin
      exp_q.delete();
      cnt_m = 0;
    end
    refresh();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    fifo.delete();
    refresh();
    tick();
    tick();
    rrst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int  n = 0;
    logic done;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (fifo.size() == 0 && exp_q.size() == 0 && !busy && !bus.m_valid);
    end
    chk("drain_done", {31'd0, done}, 1);
  endtask

  // Monitor: stream stability and in-order delivery against the scoreboard.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  initial begin
    forever begin
      @(negedge rclk);
      if (!rrst) begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, bus.m_valid}, 1);
          chk("hold_data", bus.m_data, prev_data);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_data: got unexpected 0x%0h expected no word", bus.m_data);
          end else begin
            chk("stream_data", bus.m_data, exp_q.pop_front());
          end
          chk("rd_count_hs", rd_count, cnt_m);
          cnt_m = (cnt_m + 1) % (1 << CNT_W);
          hs_total++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int n, h0, re_cnt;
    bus.data_read = '0;
    bus.m_ready   = 1'b1;
    refresh();

    // Reset held with a word waiting; nothing may happen until the timeout.
    en = 1'b1;
    push_word(9'h1A5);
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_read_enable", {31'd0, re_pend}, 0);
      chk("rst_m_valid", {31'd0, bus.m_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rd_count", rd_count, 0);
    end
    rrst = 1'b0;
    n = 0; re_cnt = 0;
    while (!busy && n < 40) begin
      tick();
      n++;
      if (re_pend) re_cnt++;
    end
    chk("rst_first_trigger", n, FT);
    chk("rst_no_early_read", re_cnt, 0);
    wait_drain(40);

    // Timeout flush of a single idle word.
    do_reset();
    push_word(9'h1A5);
    n = 0;
    while (!busy && n < 40) begin
      tick();
      n++;
    end
    chk("flush_latency", n, FT);
    tick();
    chk("flush_first_read", {31'd0, re_pend}, 1);
    wait_drain(40);
    chk("flush_rd_count", rd_count, 1);

    // Half-full drain: two-cycle startup then one word per cycle.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(9'(256 + i));
    tick();
    chk("drain_busy_rise", {31'd0, busy}, 1);
    h0 = hs_total; n = 1;
    while (hs_total - h0 < 10 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_cycles", n, 13);
    wait_drain(20);
    chk("drain_rd_count", rd_count, 10);
    chk("drain_back_idle", {31'd0, busy}, 0);

    // Back-pressure: buffer fills with exactly BUF_DEPTH reads.
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(9'(256 + i));
    re_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (re_pend) re_cnt++;
    end
    chk("bp_read_count", re_cnt, BUF_DEPTH);
    chk("bp_m_valid", {31'd0, bus.m_valid}, 1);
    chk("bp_m_data", bus.m_data, 9'h100);
    bus.m_ready = 1'b1;
    wait_drain(40);
    chk("bp_rd_count", rd_count, 8);

    // en dropped while a read is in flight.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(9'(256 + i));
    tick();
    tick();
    chk("endrop_inflight", {31'd0, re_pend}, 1);
    h0 = hs_total;
    en = 1'b0;
    re_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (re_pend) re_cnt++;
    end
    chk("endrop_no_read", re_cnt, 0);
    chk("endrop_busy", {31'd0, busy}, 0);
    chk("endrop_delivered", hs_total - h0, 1);
    en = 1'b1;
    wait_drain(40);

    // Reset in the cycle a read is issued: the returning word is discarded.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(9'(256 + i));
    tick();
    rrst = 1'b1;
    tick();
    chk("rstmid_read_issued", {31'd0, re_pend}, 1);
    rrst = 1'b0;
    tick();
    chk("rstmid_m_valid_a", {31'd0, bus.m_valid}, 0);
    tick();
    chk("rstmid_m_valid_b", {31'd0, bus.m_valid}, 0);
    wait_drain(40);
    chk("rstmid_rd_count", rd_count, 9);

    // Randomized traffic: enable, back-pressure and arrivals all random.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en          = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          if (fifo.size() < 16) push_word(DW'($urandom_range(0, 511)));
      end
      tick();
    end
    en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(80);

    // 2^CNT_W handshakes wrap the delivered-word counter to zero.
    do_reset();
    h0 = hs_total;
    for (int i = 0; i < (1 << CNT_W); i++) fifo.push_back(DW'($urandom_range(0, 511)));
    refresh();
    wait_drain((1 << CNT_W) + 200);
    chk("wrap_handshakes", hs_total - h0, 1 << CNT_W);
    chk("wrap_rd_count", rd_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
